vga_sprite_compositor: RTL and testbench

- Parametrised successor to the top-level pixel drawer: composites NUM_SPRITES priority-ordered sprites over the background colour on a registered 2-stage pipeline.
- Adds transparency keying, per-frame shadowing of sprite positions (no mid-frame tearing) and sprite-0-vs-others pixel-accurate collision flags reported once per frame.
- Sits between the VGA timing generator / environment drawer and the RGB output pins; per-sprite ROM drawers hang off its local-coordinate outputs.

---
 rtl/vga_sprite_compositor.sv | 146 ++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_compositor.sv
// Purpose : composites NUM_SPRITES priority-ordered sprites (0 = highest) over the background
//           with colour-key transparency, per-frame position shadowing and sprite-0 collision flags.
// Latency : row/col at cycle N -> red/green/blue/rgb_valid at N+2; no backpressure, one pixel per cycle.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   frame_start           one-cycle pulse before the first active pixel; latches sprite shadows
//   pixel_valid/row/col/bg_rgb   incoming pixel stream from the timing/environment drawer
//   sprite_x/y/en         live sprite positions and enables (sampled only at frame_start)
//   local_x/local_y       registered sprite-local coordinates to the per-sprite drawers
//   sprite_rgb            combinational drawer colours for local_x/local_y
//   red/green/blue, rgb_valid   composited output pixel
//   collision, collision_valid  sprite 0 vs sprite i overlap of the previous frame
module vga_sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPRITE_SIZE = 42,
    parameter int          COORD_W     = 32,
    parameter int          LOCAL_W     = 6,
    parameter logic [11:0] KEY_RGB     = 12'hF0F
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           pixel_valid,
    input  logic [COORD_W-1:0]             row,
    input  logic [COORD_W-1:0]             col,
    input  logic [11:0]                    bg_rgb,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    output logic [NUM_SPRITES*LOCAL_W-1:0] local_x,
    output logic [NUM_SPRITES*LOCAL_W-1:0] local_y,
    input  logic [NUM_SPRITES*12-1:0]      sprite_rgb,
    output logic [3:0]                     red,
    output logic [3:0]                     green,
    output logic [3:0]                     blue,
    output logic                           rgb_valid,
    output logic [NUM_SPRITES-2:0]         collision,
    output logic                           collision_valid
);

    localparam logic signed [COORD_W-1:0] SIZE_C = COORD_W'(SPRITE_SIZE);

    // Shadowed sprite state: only changes at frame boundaries so a frame never tears.
    logic [NUM_SPRITES*COORD_W-1:0] sh_x, sh_y;
    logic [NUM_SPRITES-1:0]         sh_en;

    logic [NUM_SPRITES-1:0]         hit_d, hit1;
    logic [NUM_SPRITES*LOCAL_W-1:0] lx_d, ly_d;
    logic [11:0]                    bg1;
    logic                           valid1;

    logic [NUM_SPRITES-1:0]         opaque;
    logic [11:0]                    pix_d;
    logic [NUM_SPRITES-2:0]         coll_set, acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_x  <= '0;
            sh_y  <= '0;
            sh_en <= '0;
        end else if (frame_start) begin
            sh_x  <= sprite_x;
            sh_y  <= sprite_y;
            sh_en <= sprite_en;
        end
    end

    // Stage 1: bounding-box hit test against the shadows (old shadows on a frame_start cycle).
    always_comb begin
        hit_d = '0;
        lx_d  = '0;
        ly_d  = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_d[i] = sh_en[i]
                && ($signed(col) >= $signed(sh_x[i*COORD_W +: COORD_W]))
                && ($signed(col) <  $signed(sh_x[i*COORD_W +: COORD_W]) + SIZE_C)
                && ($signed(row) >= $signed(sh_y[i*COORD_W +: COORD_W]))
                && ($signed(row) <  $signed(sh_y[i*COORD_W +: COORD_W]) + SIZE_C);
            // Truncated offsets; only meaningful when the sprite is hit.
            lx_d[i*LOCAL_W +: LOCAL_W] = LOCAL_W'(col - sh_x[i*COORD_W +: COORD_W]);
            ly_d[i*LOCAL_W +: LOCAL_W] = LOCAL_W'(row - sh_y[i*COORD_W +: COORD_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit1    <= '0;
            local_x <= '0;
            local_y <= '0;
            bg1     <= '0;
            valid1  <= 1'b0;
        end else begin
            hit1    <= hit_d;
            local_x <= lx_d;
            local_y <= ly_d;
            bg1     <= bg_rgb;
            valid1  <= pixel_valid;
        end
    end

    // Stage 2: priority select. Walking from lowest priority upward lets sprite 0 win last;
    // keyed pixels are skipped so they fall through to the next sprite or the background.
    always_comb begin
        opaque   = '0;
        coll_set = '0;
        pix_d    = bg1;
        for (int i = 0; i < NUM_SPRITES; i++)
            opaque[i] = (sprite_rgb[i*12 +: 12] != KEY_RGB);
        for (int i = NUM_SPRITES-1; i >= 0; i--)
            if (hit1[i] && opaque[i])
                pix_d = sprite_rgb[i*12 +: 12];
        if (!valid1)
            pix_d = '0;
        for (int i = 1; i < NUM_SPRITES; i++)
            coll_set[i-1] = valid1 && hit1[0] && opaque[0] && hit1[i] && opaque[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {red, green, blue} <= '0;
            rgb_valid          <= 1'b0;
        end else begin
            {red, green, blue} <= pix_d;
            rgb_valid          <= valid1;
        end
    end

    // The pixel still in stage 2 on the frame_start cycle belongs to the closing frame,
    // so its collision term is folded into the report rather than the new accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc             <= '0;
            collision       <= '0;
            collision_valid <= 1'b0;
        end else if (frame_start) begin
            collision       <= acc | coll_set;
            acc             <= '0;
            collision_valid <= 1'b1;
        end else begin
            acc             <= acc | coll_set;
            collision_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
module tb_vga_sprite_compositor;

    localparam int          N   = 4;
    localparam int          SZ  = 42;
    localparam int          CW  = 32;
    localparam int          LW  = 6;
    localparam logic [11:0] KEY = 12'hF0F;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              pixel_valid;
    logic [CW-1:0]     row, col;
    logic [11:0]       bg_rgb;
    logic [N*CW-1:0]   sprite_x, sprite_y;
    logic [N-1:0]      sprite_en;
    logic [N*LW-1:0]   local_x, local_y;
    logic [N*12-1:0]   sprite_rgb;
    logic [3:0]        red, green, blue;
    logic              rgb_valid;
    logic [N-2:0]      collision;
    logic              collision_valid;

    always #5 clk = ~clk;

    vga_sprite_compositor #(
        .NUM_SPRITES(N), .SPRITE_SIZE(SZ), .COORD_W(CW), .LOCAL_W(LW), .KEY_RGB(KEY)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .row(row), .col(col), .bg_rgb(bg_rgb),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .local_x(local_x), .local_y(local_y), .sprite_rgb(sprite_rgb),
        .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
        .collision(collision), .collision_valid(collision_valid)
    );

    // Live sprite registers seen by the DUT, and the bench's own shadow copy.
    int          sx[N], sy[N];
    bit          sen[N];
    int          mx[N], my[N];
    bit          men[N];
    logic [11:0] base[N];
    bit          key33;
    logic [2:0]  model_acc;

    logic [11:0] q[$];
    int          n_chk = 0;
    int          n_err = 0;
    bit          mon_on = 0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            sprite_x[i*CW +: CW] = sx[i];
            sprite_y[i*CW +: CW] = sy[i];
            sprite_en[i]         = sen[i];
        end
    end

    // Drawer models: flat colour per sprite; sprite 0 optionally keyed at local (3,3).
    always_comb begin
        for (int i = 0; i < N; i++) sprite_rgb[i*12 +: 12] = base[i];
        if (key33 && local_x[5:0] == 6'd3 && local_y[5:0] == 6'd3) sprite_rgb[11:0] = KEY;
    end

    function automatic logic [11:0] draw(int i, int lx, int ly);
        if (i == 0 && key33 && lx == 3 && ly == 3) return KEY;
        return base[i];
    endfunction

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (rgb_valid) begin
                if (q.size() == 0) check("unexpected_px", 32'd1, 32'd0);
                else check("rgb", {20'd0, red, green, blue}, {20'd0, q.pop_front()});
            end else begin
                check("idle_rgb", {20'd0, red, green, blue}, 32'd0);
            end
        end
    end

    task automatic load_shadows();
        for (int i = 0; i < N; i++) begin
            mx[i] = sx[i]; my[i] = sy[i]; men[i] = sen[i];
        end
    endtask

    // Drives one pixel at a negedge, returns at the next negedge after checking stage-1 locals.
    task automatic drive_px(int r, int c, logic [11:0] bg, bit fs = 0);
        bit          h[N];
        int          lx[N], ly[N];
        logic [11:0] cl[N];
        logic [11:0] exp;
        logic [2:0]  cs, exp_coll;
        exp = bg;
        cs  = '0;
        exp_coll = '0;
        for (int i = 0; i < N; i++) begin
            h[i]  = men[i] && c >= mx[i] && c < mx[i] + SZ && r >= my[i] && r < my[i] + SZ;
            lx[i] = (c - mx[i]) & 63;
            ly[i] = (r - my[i]) & 63;
            cl[i] = draw(i, lx[i], ly[i]);
        end
        for (int i = N-1; i >= 0; i--)
            if (h[i] && cl[i] != KEY) exp = cl[i];
        for (int i = 1; i < N; i++)
            if (h[0] && h[i] && cl[0] != KEY && cl[i] != KEY) cs[i-1] = 1'b1;
        row = r; col = c; bg_rgb = bg; pixel_valid = 1'b1; frame_start = fs;
        q.push_back(exp);
        if (fs) begin
            exp_coll  = model_acc;
            model_acc = '0;
            load_shadows();
        end
        model_acc |= cs;
        @(negedge clk);
        pixel_valid = 1'b0; frame_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (h[i]) begin
                check("local_x", {26'd0, local_x[i*LW +: LW]}, lx[i]);
                check("local_y", {26'd0, local_y[i*LW +: LW]}, ly[i]);
            end
        end
        if (fs) begin
            check("fs_coll_valid", {31'd0, collision_valid}, 32'd1);
            check("fs_collision", {29'd0, collision}, {29'd0, exp_coll});
        end
    endtask

    task automatic pulse_frame();
        logic [2:0] exp_coll;
        frame_start = 1'b1;
        exp_coll  = model_acc;
        model_acc = '0;
        load_shadows();
        @(negedge clk);
        frame_start = 1'b0;
        check("coll_valid_hi", {31'd0, collision_valid}, 32'd1);
        check("collision", {29'd0, collision}, {29'd0, exp_coll});
        @(negedge clk);
        check("coll_valid_lo", {31'd0, collision_valid}, 32'd0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_rgb"}, {20'd0, red, green, blue}, 32'd0);
        check({tag, "_rgb_valid"}, {31'd0, rgb_valid}, 32'd0);
        check({tag, "_collision"}, {29'd0, collision}, 32'd0);
        check({tag, "_coll_valid"}, {31'd0, collision_valid}, 32'd0);
        check({tag, "_local_x"}, {8'd0, local_x}, 32'd0);
        check({tag, "_local_y"}, {8'd0, local_y}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0;
        row = '0; col = '0; bg_rgb = '0; key33 = 0; model_acc = '0;
        for (int i = 0; i < N; i++) begin
            sx[i] = 0; sy[i] = 0; sen[i] = 0; mx[i] = 0; my[i] = 0; men[i] = 0;
        end
        base[0] = 12'hF00; base[1] = 12'h0F0; base[2] = 12'h00F; base[3] = 12'h888;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        mon_on = 1;
        @(negedge clk);

        // First frame after reset: nothing accumulated yet.
        pulse_frame();

        // Single sprite edges.
        sx[0] = 100; sy[0] = 200; sen[0] = 1;
        pulse_frame();
        drive_px(200, 100, 12'h123);
        drive_px(200, 141, 12'h123);
        drive_px(200, 142, 12'h456);
        drive_px(199, 100, 12'h789);
        drive_px(241, 100, 12'h321);
        drive_px(242, 100, 12'h654);

        // Mid-frame position change stays invisible until the next frame.
        sx[0] = 300;
        drive_px(200, 300, 12'h111);
        drive_px(200, 100, 12'h222);
        pulse_frame();
        drive_px(200, 300, 12'h333);
        drive_px(200, 100, 12'h444);

        // Overlap with keyed pixel falling through to sprite 1.
        sx[0] = 50; sy[0] = 50; sx[1] = 50; sy[1] = 50; sen[1] = 1; key33 = 1;
        pulse_frame();
        drive_px(53, 53, 12'h0AA);
        drive_px(52, 53, 12'h0AA);
        drive_px(53, 54, 12'h0AA);
        pulse_frame();

        // Sprite 0 vs sprite 2 overlap, then a clean frame.
        key33 = 0; sen[1] = 0;
        sx[0] = 10; sy[0] = 10; sx[2] = 30; sy[2] = 30; sen[2] = 1;
        pulse_frame();
        for (int r = 28; r <= 32; r += 2)
            for (int c = 28; c <= 32; c += 2)
                drive_px(r, c, 12'h0C3);
        pulse_frame();
        drive_px(12, 12, 12'h5A5);
        drive_px(60, 60, 12'h5A5);
        pulse_frame();

        // Off-screen negative position and a disabled sprite on top of it.
        sen[0] = 0; sen[2] = 0;
        sx[3] = -20; sy[3] = 0; sen[3] = 1;
        sx[1] = 0; sy[1] = 0; sen[1] = 0;
        sx[0] = 0; sy[0] = 0;
        pulse_frame();
        drive_px(0, 0, 12'h0E1);
        drive_px(5, 21, 12'h0E1);
        drive_px(5, 22, 12'h0E1);

        // Frame start coincident with a pixel: pixel uses the old shadows.
        sx[3] = 200;
        drive_px(1, 1, 12'h0D2, 1);
        drive_px(1, 1, 12'h0D2);
        pulse_frame();

        // Reset mid-frame with the accumulator set and a pixel in flight.
        sen[3] = 0;
        sx[0] = 10; sy[0] = 10; sen[0] = 1; sx[2] = 30; sy[2] = 30; sen[2] = 1;
        pulse_frame();
        drive_px(31, 31, 12'h0B4);
        drive_px(32, 32, 12'h0B4);
        reset = 1'b1;
        void'(q.pop_back());
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        model_acc = '0;
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; men[i] = 0;
        end
        drive_px(31, 31, 12'h0B4);
        pulse_frame();
        drive_px(31, 31, 12'h0B4);

        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
